// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-scan debounce, ghost rejection and valid/ready key output.
// Define KEYPAD_REPEAT_EN to re-emit a held key after REPEAT_DELAY scans and then every REPEAT_RATE scans.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEB_SCANS    = 4,
    parameter int REPEAT_DELAY = 60,
    parameter int REPEAT_RATE  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(DEB_SCANS + 1);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, REL_DEB} state_t;

    if (SCAN_DIV < 2 || DEB_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scanner: parameter out of range");
    end

    logic [CW-1:0] div;
    logic [1:0]    row;
    logic [11:0]   samp;
    logic [15:0]   full;
    logic [3:0]    enc;
    logic          tc, scan_pulse;
    logic [4:0]    res, prev;
    logic [NW-1:0] deb, deb_n;
    logic          is_key, deb_ok, accept, emit;
    logic [3:0]    emit_code;
    state_t        state, state_n;

    assign tc      = div == CW'(SCAN_DIV - 1);
    assign row_out = ~(4'b0001 << row);
    assign full    = {~col_in, samp};

    always_comb begin
        enc = '0;
        for (int i = 0; i < 16; i++)
            if (full[i]) enc = 4'(i);
    end

    // res is {is_key, code}; NONE and MULTI both collapse to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            row        <= '0;
            samp       <= '0;
            res        <= '0;
            scan_pulse <= 1'b0;
        end else begin
            scan_pulse <= tc && row == 2'd3;
            div        <= tc ? '0 : div + 1'b1;
            if (tc) begin
                row  <= row + 1'b1;
                samp <= row == 2'd3 ? '0 : samp | ({8'b0, ~col_in} << {row, 2'b00});
                if (row == 2'd3)
                    res <= (full != '0 && (full & (full - 16'd1)) == '0) ? {1'b1, enc} : '0;
            end
        end
    end

    assign is_key = res[4];
    assign deb_n  = res != prev ? NW'(1) : deb == NW'(DEB_SCANS) ? deb : deb + 1'b1;
    assign deb_ok = deb_n == NW'(DEB_SCANS);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            deb  <= '0;
        end else if (scan_pulse) begin
            prev <= res;
            deb  <= deb_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (scan_pulse)
            state_n = key_held ? (is_key ? PRESSED : deb_ok ? IDLE : REL_DEB)
                               : (!is_key ? IDLE : deb_ok ? PRESSED : PRESS_DEB);
    end

    always_comb begin
        key_held = state == PRESSED || state == REL_DEB;
        accept   = scan_pulse && !key_held && is_key && deb_ok;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_first, rep_step, rep_fire;
    logic [3:0]    hold_code;

    assign rep_step  = scan_pulse && state == PRESSED && is_key;
    assign rep_fire  = rep_step && rep_cnt + 1'b1 == RW'(rep_first ? REPEAT_RATE : REPEAT_DELAY);
    assign emit      = accept || rep_fire;
    assign emit_code = accept ? res[3:0] : hold_code;

    // cleared only once the press is fully released, so a release bounce keeps the cadence
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (rep_step) begin
            rep_cnt   <= rep_fire ? '0 : rep_cnt + 1'b1;
            rep_first <= rep_first || rep_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         hold_code <= '0;
        else if (accept) hold_code <= res[3:0];
    end
`else
    assign emit      = accept;
    assign emit_code = res[3:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (emit && key_valid && !key_ready) begin
            overrun <= 1'b1;
        end else if (emit) begin
            key_code  <= emit_code;
            key_valid <= 1'b1;
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end
endmodule
